// File: rtl/keypad_entry_controller_if.sv
// Keypad entry controller bus: encoder inputs, consumer read handshake and
// status outputs grouped into one bundle.
//
// Handshake: rd_valid high means rd_data holds the head entry; the consumer
// asserts rd_en for one cycle to pop it. The pop takes effect on the rising
// edge where rd_en=1 and rd_valid=1. rd_en while rd_valid=0 has no effect.
// code_in/valid_in are level signals from the encoder, not a handshake.
interface keypad_entry_controller_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]       code_in;
  logic             valid_in;
  logic             rd_en;
  logic             clear_ovf;
  logic [3:0]       rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] count;
  logic             key_down;
  logic             overflow;

  // Controller side
  modport master (
    input  code_in, valid_in, rd_en, clear_ovf,
    output rd_data, rd_valid, count, key_down, overflow
  );

  // Encoder/consumer side
  modport slave (
    output code_in, valid_in, rd_en, clear_ovf,
    input  rd_data, rd_valid, count, key_down, overflow
  );
endinterface

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller: debounces encoder code/valid into press and
// release events, queues one code per qualified press in a show-ahead FIFO
// and flags dropped codes with a sticky overflow.
//
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
// Debug: dbg_state_o shows the FSM state (0 IDLE, 1 DEBOUNCE, 2 HELD,
// 3 RELEASE).
module keypad_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_DELAY  = 64
  , parameter int REPEAT_RATE   = 16
`endif
) (
  input  logic                             clock,
  input  logic                             reset,
  keypad_entry_controller_if.master        bus,
  output logic [1:0]                       dbg_state_o
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_N  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic              press_push;
  logic              push_req;
  logic              key_down_q;

  logic [3:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q;
  logic              pop, full, push_ok, drop;

  // Debounce/press-tracking next-state logic
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    press_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in) begin
          cand_d  = bus.code_in;
          cnt_d   = DB_W'(1);
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!bus.valid_in) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.code_in != cand_q) begin
          // Code changed mid-debounce: restart on the new code
          cand_d = bus.code_in;
          cnt_d  = DB_W'(1);
        end else if (cnt_q == DB_LAST) begin
          press_push = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HELD;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      ST_HELD: begin
        // A different code while held is ignored: first key owns the entry
        if (!bus.valid_in) begin
          cnt_d   = DB_W'(1);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus.valid_in) begin
          if (bus.code_in == cand_q) begin
            // Release bounce: resume holding, no new push
            cnt_d   = '0;
            state_d = ST_HELD;
          end else begin
            cand_d  = bus.code_in;
            cnt_d   = DB_W'(1);
            state_d = ST_DEBOUNCE;
          end
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM registers; key_down is decoded from the next state so it tracks state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cand_q     <= 4'h0;
      cnt_q      <= '0;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      key_down_q <= (state_d == ST_HELD) || (state_d == ST_RELEASE);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  logic             rep_stay;
  logic             rep_fire;

  assign rep_stay = (state_q == ST_HELD) && (state_d == ST_HELD);
  assign rep_fire = rep_stay &&
                    (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY - 1)
                                               : REP_W'(REPEAT_RATE - 1)));
  assign push_req = press_push | rep_fire;

  // Repeat timer: restarts on every entry into HELD, first interval is the delay
  always_ff @(posedge clock) begin
    if (!reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (!rep_stay) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_q + REP_W'(1);
    end
  end
`else
  assign push_req = press_push;
`endif

  assign pop     = bus.rd_en && (count_q != '0);
  assign full    = (count_q == FULL_N);
  // A pop in the same cycle frees the slot, so a push at full still fits
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // Occupancy next value
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since empty reads are forced to 0
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= cand_q;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear)
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.clear_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 4'h0;
  assign bus.rd_valid = (count_q != '0);
  assign bus.count    = count_q;
  assign bus.key_down = key_down_q;
  assign bus.overflow = overflow_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Testbench for keypad_entry_controller (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Inputs change on the falling edge; outputs are compared on the falling
// edge after the rising edge that consumed them.
module tb_keypad_entry_controller;

  localparam int FD = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  keypad_entry_controller_if #(.FIFO_DEPTH(FD)) bus ();

  keypad_entry_controller #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       re;
    logic       clr;
    logic       e_rv;
    logic [3:0] e_data;
    logic [2:0] e_cnt;
    logic       e_kd;
    logic       e_ovf;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  // Scoreboard of codes expected to come out of the FIFO, in order
  logic [3:0] exp_q[$];

  function automatic vec_t mk(logic v, logic [3:0] c, logic re, logic clr,
                              logic rv, logic [3:0] d, logic [2:0] n,
                              logic kd, logic ov, logic [1:0] st);
    vec_t r;
    r.v = v; r.c = c; r.re = re; r.clr = clr;
    r.e_rv = rv; r.e_data = d; r.e_cnt = n; r.e_kd = kd; r.e_ovf = ov; r.e_st = st;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, return at the next falling edge
  task automatic cyc(input logic v, input logic [3:0] c, input logic re, input logic clr);
    bus.valid_in  = v;
    bus.code_in   = c;
    bus.rd_en     = re;
    bus.clear_ovf = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic press(input logic [3:0] c);
    for (int i = 0; i < 4; i++) cyc(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic release_key();
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // Pop one entry and compare it to the scoreboard head
  task automatic pop_check(input string name);
    logic [3:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
    chk({name, "_valid"}, 32'(bus.rd_valid), 32'(1));
    chk({name, "_data"}, 32'(bus.rd_data), 32'(e));
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({bus.rd_valid, bus.rd_data, bus.count, bus.key_down, bus.overflow, dbg_state});
  endfunction

  initial begin
    bus.valid_in = 1'b0; bus.code_in = 4'h0; bus.rd_en = 1'b0; bus.clear_ovf = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    // Vector table: clean press of 7, short press of A, re-latch in debounce
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'h7, 0, 0, 0, 4'h0, 3'd0, 0, 0, 2'd1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 4'h7, 0, 0, 1, 4'h7, 3'd1, 1, 0, 2'd2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'h7, 0, 0, 1, 4'h7, 3'd1, 1, 0, 2'd3));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 4'h7, 0, 0, 1, 4'h7, 3'd1, 0, 0, 2'd0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 0, 0, 2'd0));   // pop the 7
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 0, 0, 2'd0));   // pop while empty
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'hA, 0, 0, 0, 4'h0, 3'd0, 0, 0, 2'd1));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 4'hA, 0, 0, 0, 4'h0, 3'd0, 0, 0, 2'd0));
    vecs.push_back(mk(1, 4'h1, 0, 0, 0, 4'h0, 3'd0, 0, 0, 2'd1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'h2, 0, 0, 0, 4'h0, 3'd0, 0, 0, 2'd1));
    vecs.push_back(mk(1, 4'h2, 0, 0, 1, 4'h2, 3'd1, 1, 0, 2'd2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h2, 3'd1, 1, 0, 2'd3));
    vecs.push_back(mk(0, 4'h0, 0, 0, 1, 4'h2, 3'd1, 0, 0, 2'd0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 3'd0, 0, 0, 2'd0));

    do_reset();
    chk("reset_state", pack_out(), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].v, vecs[i].c, vecs[i].re, vecs[i].clr);
      chk($sformatf("vec%0d", i), pack_out(),
          32'({vecs[i].e_rv, vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_kd,
               vecs[i].e_ovf, vecs[i].e_st}));
    end

    // Release bounce and rollover ignore: one entry for key 3, then key 5
    do_reset();
    press(4'h3); exp_q.push_back(4'h3);
    cyc(1'b1, 4'h6, 1'b0, 1'b0);
    chk("held_ignores_other_state", 32'(dbg_state), 32'(2));
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("bounce_in_release", 32'(dbg_state), 32'(3));
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    chk("bounce_back_held", 32'(dbg_state), 32'(2));
    chk("bounce_no_push", 32'(bus.count), 32'(1));
    release_key();
    press(4'h5); exp_q.push_back(4'h5);
    release_key();
    chk("two_entries", 32'(bus.count), 32'(2));
    pop_check("pop3");
    chk("after_pop_data", 32'(bus.rd_data), 32'(5));
    pop_check("pop5");
    chk("empty_after_pops", 32'({bus.rd_valid, bus.count}), 32'(0));

    // Overflow: five presses into a depth-4 FIFO
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      press(4'(k));
      if (k <= 4) exp_q.push_back(4'(k));
      release_key();
      if (k == 4) chk("full_no_ovf", 32'({bus.count, bus.overflow}), 32'({3'd4, 1'b0}));
    end
    chk("ovf_set", 32'({bus.count, bus.overflow}), 32'({3'd4, 1'b1}));
    chk("ovf_head", 32'(bus.rd_data), 32'(1));
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(bus.overflow), 32'(0));
    // Drop coinciding with clear: set wins
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h6, 1'b0, 1'b0);
    cyc(1'b1, 4'h6, 1'b0, 1'b1);
    chk("ovf_set_beats_clear", 32'(bus.overflow), 32'(1));
    release_key();
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf_cleared2", 32'(bus.overflow), 32'(0));
    // Push with simultaneous pop at full: both happen
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h7, 1'b0, 1'b0);
    cyc(1'b1, 4'h7, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(4'h7);
    chk("push_pop_full", 32'({bus.count, bus.overflow}), 32'({3'd4, 1'b0}));
    chk("push_pop_head", 32'(bus.rd_data), 32'(2));
    release_key();
    pop_check("drain0"); pop_check("drain1"); pop_check("drain2"); pop_check("drain3");
    chk("drained", 32'(bus.count), 32'(0));

    // Reset mid-debounce with two entries queued
    do_reset();
    press(4'h8); release_key();
    press(4'h9); release_key();
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    chk("pre_reset", 32'({bus.count, dbg_state}), 32'({3'd2, 2'd1}));
    rst_n = 1'b0;
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_reset", pack_out(), 32'h0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("no_push_after_reset", 32'({bus.count, bus.rd_valid}), 32'(0));

    // Long hold: auto-repeat when enabled, single entry otherwise
    do_reset();
    press(4'h9);
    chk("hold_qualify", 32'(bus.count), 32'(1));
`ifdef KEYPAD_REPEAT_EN
    for (int i = 1; i <= 63; i++) cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("rep_before_delay", 32'(bus.count), 32'(1));
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("rep_at_delay", 32'(bus.count), 32'(2));
    for (int i = 65; i <= 70; i++) cyc(1'b1, 4'h9, i == 70, 1'b0);
    chk("rep_after_pop", 32'(bus.count), 32'(1));
    for (int i = 71; i <= 79; i++) cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("rep_before_rate", 32'(bus.count), 32'(1));
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("rep_at_rate", 32'({bus.count, bus.rd_data}), 32'({3'd2, 4'h9}));
`else
    for (int i = 0; i < 90; i++) cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("no_repeat", 32'({bus.count, dbg_state}), 32'({3'd1, 2'd2}));
`endif
    release_key();
    chk("hold_released", 32'({bus.key_down, dbg_state}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
- Sits downstream of the hex keypad encoder (after the row synchronizer path) and sequences key entry for the rest of the design.
- Qualifies raw code/valid into debounced press and release events.
- Enqueues one 4-bit code per qualified press into a small show-ahead FIFO.
- Hands codes to a consumer with a read-enable handshake and flags lost keys with a sticky overflow.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive matching samples needed to accept a press or a release; legal range is 2 or more.
- FIFO_DEPTH, 4: code buffer entries; must be a power of two, 2 or more.
- REPEAT_DELAY, 64: cycles of hold before the first auto-repeat (optional feature only).
- REPEAT_RATE, 16: cycles between subsequent auto-repeats (optional feature only).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- code_in  in  4  key code from the encoder.
- valid_in  in  1  high while the encoder reports a pressed key (level).
- rd_en  in  1  consumer pops the head entry.
- rd_data  out  4  head-of-FIFO code (show-ahead).
- rd_valid  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- key_down  out  1  high in HELD and RELEASE.
- overflow  out  1  sticky; a qualified press was dropped because the FIFO was full.
- clear_ovf  in  1  clears overflow.

Behaviour:
- Reset (reset==0 at an edge):
  - FSM goes to IDLE; debounce counter=0.
  - FIFO pointers=0, count=0, rd_valid=0, rd_data=0.
  - key_down=0, overflow=0.
  - A press in progress is discarded; no push.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Registers: cand[3:0] (latched code) and cnt.
- IDLE:
  - valid_in=1: latch cand=code_in, cnt=1, go to DEBOUNCE.
- DEBOUNCE:
  - valid_in=1 and code_in==cand: cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 and the sample matches: push cand, go to HELD.
  - valid_in=0: go to IDLE.
  - code_in!=cand: re-latch cand=code_in, cnt=1, stay in DEBOUNCE.
- HELD:
  - valid_in=0: go to RELEASE, cnt=1.
  - valid_in=1 with a different code: ignored (no rollover); the first key owns the entry until released.
- RELEASE:
  - valid_in=0 for DEBOUNCE_CYCLES consecutive edges: go to IDLE.
  - valid_in=1 with code==cand: back to HELD, no push (bounce).
  - valid_in=1 with a different code: go to DEBOUNCE with cand=code_in, cnt=1.
- Latency:
  - valid_in stable across D=DEBOUNCE_CYCLES consecutive edges gives a push on the D-th edge.
  - rd_valid and rd_data are visible immediately after that edge.
- FIFO:
  - Circular buffer with pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
  - rd_data always equals the head entry; it is 0-held/don't-care when empty but is driven 0.
  - Pop occurs when rd_en=1 and count>0; rd_en while empty is ignored with no underflow.
  - Push while count==FIFO_DEPTH and no pop in the same cycle: code dropped, overflow<=1.
  - Push and pop in the same cycle, at any occupancy including full: both occur, count unchanged, no overflow.
- overflow:
  - Set has priority over clear_ovf when both occur in the same cycle.
  - Otherwise clear_ovf=1 clears it.
- key_down is a registered decode of the state.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at entry.
  - After REPEAT_DELAY cycles in HELD, cand is pushed again; thereafter it is pushed every REPEAT_RATE cycles.
  - Repeat pushes obey the same full/overflow rules.
  - Leaving HELD resets the repeat counter; a bounce through RELEASE back to HELD restarts the delay.
- Undefined:
  - Exactly one push per qualified press.
  - No repeat counter logic is present.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
1. Reset, then code_in=4'h7 with valid_in=1 held 10 cycles, then 0 for 10 cycles -> exactly one entry 7; rd_valid rises after the 4th valid edge; key_down falls 4 cycles after valid_in drops.
2. valid_in=1 for 3 cycles only (code 4'hA), then 0 -> no push, count=0, state returns to IDLE.
3. Press 3 held, valid_in drops for 2 cycles then returns with 3 -> single entry; a second press of 5 after a clean release -> FIFO contents 3 then 5; rd_en pops 3 and rd_data shows 5.
4. Five clean presses 1,2,3,4,5 with no reads -> count=4, overflow=1, FIFO holds 1..4; clear_ovf -> overflow=0; a press coinciding with rd_en at full -> count stays 4, overflow stays 0.
5. Reset asserted mid-DEBOUNCE and with 2 entries queued -> count=0, rd_valid=0, key_down=0, overflow=0 on the next edge; no push afterward.
6. (KEYPAD_REPEAT_EN, REPEAT_DELAY=64, REPEAT_RATE=16) key 9 held 100 cycles after qualification -> pushes at qualify+64 and qualify+80 (3 entries total), with a pop between to avoid overflow.
